// File: rtl/z16_io_pkg.sv
// rtl/z16_io_pkg.sv - shared Z16 board I/O constants and types
package z16_io_pkg;

    localparam int Z16_CLK_HZ        = 27_000_000;
    localparam int Z16_DEBOUNCE_10MS = 270_000;

    typedef enum logic {
        FILT_STABLE   = 1'b0,
        FILT_COUNTING = 1'b1
    } filt_state_e;

endpackage

// File: rtl/z16_button_debounce_if.sv
// rtl/z16_button_debounce_if.sv - button conditioning signals between board and debouncer
interface z16_button_debounce_if;

    logic       i_button;
    logic       i_ack;
    logic       o_level;
    logic       o_press;
    logic       o_release;
    logic       o_pending;
    logic [7:0] o_press_count;

    modport master (
        output i_button, i_ack,
        input  o_level, o_press, o_release, o_pending, o_press_count
    );

    modport slave (
        input  i_button, i_ack,
        output o_level, o_press, o_release, o_pending, o_press_count
    );

endinterface

// File: rtl/z16_sync2.sv
// rtl/z16_sync2.sv - two-flop synchroniser with asynchronous active-high reset
module z16_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic s1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1  <= 1'b0;
            o_q <= 1'b0;
        end else begin
            s1  <= i_d;
            o_q <= s1;
        end
    end

endmodule

// File: rtl/z16_button_debounce.sv
// rtl/z16_button_debounce.sv - push button synchroniser, stable-count debouncer, pulses and sticky press flag
module z16_button_debounce
    import z16_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = Z16_DEBOUNCE_10MS,
    parameter int CNT_W           = 19
) (
    input  logic i_clk,
    input  logic i_rst,
    z16_button_debounce_if.slave btn
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s2;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             level_q, level_nxt;
    logic             press_q, press_nxt;
    logic             release_q, release_nxt;
    logic             pending_q, pending_nxt;
    logic [7:0]       press_count_q, press_count_nxt;
    filt_state_e      filt_state;

    z16_sync2 u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (btn.i_button),
        .o_q   (s2)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q         <= '0;
            level_q       <= 1'b0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            pending_q     <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            cnt_q         <= cnt_nxt;
            level_q       <= level_nxt;
            press_q       <= press_nxt;
            release_q     <= release_nxt;
            pending_q     <= pending_nxt;
            press_count_q <= press_count_nxt;
        end
    end

    // The filter state is implied by whether the synchronised input disagrees with the level.
    always_comb begin
        cnt_nxt     = cnt_q;
        level_nxt   = level_q;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        filt_state  = (s2 == level_q) ? FILT_STABLE : FILT_COUNTING;

        case (filt_state)
            FILT_STABLE: cnt_nxt = '0;
            FILT_COUNTING: begin
                if (cnt_q == CNT_LAST) begin
                    level_nxt   = s2;
                    cnt_nxt     = '0;
                    press_nxt   = s2;
                    release_nxt = ~s2;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_nxt = '0;
        endcase

        // A press landing together with an acknowledge must not be lost.
        if (press_nxt) begin
            pending_nxt = 1'b1;
        end else if (btn.i_ack) begin
            pending_nxt = 1'b0;
        end else begin
            pending_nxt = pending_q;
        end

        press_count_nxt = press_nxt ? press_count_q + 8'd1 : press_count_q;
    end

    assign btn.o_level       = level_q;
    assign btn.o_press       = press_q;
    assign btn.o_release     = release_q;
    assign btn.o_pending     = pending_q;
    assign btn.o_press_count = press_count_q;

endmodule

// File: tb/tb_z16_button_debounce.sv
// tb/tb_z16_button_debounce.sv - scoreboard bench for z16_button_debounce with DEBOUNCE_CYCLES=4
module tb_z16_button_debounce;

    localparam int D = 4;

    typedef struct packed {
        logic       level;
        logic       press;
        logic       rel;
        logic       pending;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exp_t exp_q[$];
    bit   btn_log[$];
    bit   seen_log[$];
    bit   m_level;
    bit   m_pending;
    bit [7:0] m_count;

    z16_button_debounce_if bif ();

    z16_button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .btn   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the filter sees the button as sampled two edges ago and flips
    // once the last D observations all disagree with the current level.
    always @(posedge clk) begin : model_b
        bit   seen;
        bit   flip;
        exp_t e;
        if (rst) begin
            btn_log.delete();
            seen_log.delete();
            m_level   = 1'b0;
            m_pending = 1'b0;
            m_count   = 8'd0;
            e         = '0;
        end else begin
            btn_log.push_back(bif.i_button);
            if (btn_log.size() > 3) void'(btn_log.pop_front());
            seen = (btn_log.size() == 3) ? btn_log[0] : 1'b0;
            seen_log.push_back(seen);
            if (seen_log.size() > D) void'(seen_log.pop_front());
            flip = (seen_log.size() == D);
            foreach (seen_log[i]) if (seen_log[i] == m_level) flip = 1'b0;
            e.press = flip && seen;
            e.rel   = flip && !seen;
            if (flip) m_level = seen;
            if (e.press) m_pending = 1'b1;
            else if (bif.i_ack) m_pending = 1'b0;
            if (e.press) m_count = m_count + 8'd1;
            e.level   = m_level;
            e.pending = m_pending;
            e.cnt     = m_count;
        end
        exp_q.push_back(e);
    end

    always @(posedge clk) begin : monitor_b
        exp_t e;
        exp_t got;
        #1;
        got = {bif.o_level, bif.o_press, bif.o_release, bif.o_pending, bif.o_press_count};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow t=%0t got %h", $time, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL sb t=%0t got lvl=%b prs=%b rel=%b pend=%b cnt=%0d expected lvl=%b prs=%b rel=%b pend=%b cnt=%0d",
                         $time, got.level, got.press, got.rel, got.pending, got.cnt,
                         e.level, e.press, e.rel, e.pending, e.cnt);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_level"},   int'(bif.o_level),       0);
        chk({name, "_press"},   int'(bif.o_press),       0);
        chk({name, "_release"}, int'(bif.o_release),     0);
        chk({name, "_pending"}, int'(bif.o_pending),     0);
        chk({name, "_count"},   int'(bif.o_press_count), 0);
    endtask

    // which: 0 waits for o_press, 1 for o_release; n = negedges since the call
    task automatic wait_pulse(input string name, input bit which, input int exp_n);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        for (int i = 1; i <= 20 && !hit; i++) begin
            @(negedge clk);
            if ((which ? bif.o_release : bif.o_press) === 1'b1) begin
                hit = 1'b1;
                n   = i;
            end
        end
        chk(name, n, exp_n);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int npress;
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bif.i_button = 1'b0;
        bif.i_ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        bif.i_button = 1'b1;
        wait_pulse("press_latency", 1'b0, D + 2);
        chk("press_level",   int'(bif.o_level), 1);
        chk("press_pending", int'(bif.o_pending), 1);
        chk("press_count",   int'(bif.o_press_count), 1);
        @(negedge clk);
        chk("press_one_cycle", int'(bif.o_press), 0);

        repeat (3) @(negedge clk);
        bif.i_button = 1'b0;
        wait_pulse("release_latency", 1'b1, D + 2);
        chk("release_level",   int'(bif.o_level), 0);
        chk("release_pending", int'(bif.o_pending), 1);
        @(negedge clk);
        chk("release_one_cycle", int'(bif.o_release), 0);

        bif.i_ack = 1'b1;
        @(negedge clk);
        bif.i_ack = 1'b0;
        chk("ack_clears", int'(bif.o_pending), 0);
        bif.i_ack = 1'b1;
        @(negedge clk);
        bif.i_ack = 1'b0;
        chk("ack_idle", int'(bif.o_pending), 0);

        pulse_rst();
        repeat (2) @(negedge clk);
        npress = 0;
        for (int i = 0; i < 4; i++) begin
            bif.i_button = (i % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                npress += int'(bif.o_press);
            end
        end
        bif.i_button = 1'b1;
        wait_pulse("bounce_latency", 1'b0, D + 2);
        chk("bounce_no_early_press", npress, 0);
        chk("bounce_count", int'(bif.o_press_count), 1);

        bif.i_button = 1'b0;
        wait_pulse("race_prep_release", 1'b1, D + 2);
        bif.i_ack = 1'b1;
        @(negedge clk);
        bif.i_ack = 1'b0;
        bif.i_button = 1'b1;
        repeat (5) @(negedge clk);
        bif.i_ack = 1'b1;
        @(negedge clk);
        chk("race_press",   int'(bif.o_press), 1);
        chk("race_pending", int'(bif.o_pending), 1);
        @(negedge clk);
        bif.i_ack = 1'b0;
        chk("race_ack_next", int'(bif.o_pending), 0);

        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_pulse("reset_held_rise", 1'b0, D + 2);
        chk("reset_held_level", int'(bif.o_level), 1);

        bif.i_button = 1'b0;
        pulse_rst();
        for (int i = 0; i < 256; i++) begin
            bif.i_button = 1'b1;
            repeat (D + 3) @(negedge clk);
            bif.i_button = 1'b0;
            repeat (D + 3) @(negedge clk);
        end
        chk("wrap_256", int'(bif.o_press_count), 0);
        bif.i_button = 1'b1;
        repeat (D + 3) @(negedge clk);
        chk("wrap_257", int'(bif.o_press_count), 1);

        repeat (400) begin
            bif.i_button = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 2 * D);
            repeat (n) begin
                bif.i_ack = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
        end
        bif.i_ack = 1'b0;
        repeat (10) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
